// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, IR field layout,
// sequencer state/class enums and the datapath strobe bundle.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Register fields sit back to back directly below the opcode: Ra, Rb, Rc.
  localparam int FLD_RA = 0;
  localparam int FLD_RB = 1;
  localparam int FLD_RC = 2;

  function automatic int field_hi(int dw, int ow, int rw, int idx);
    return dw - 1 - ow - idx * rw;
  endfunction

  typedef enum logic [2:0] {ST_IDLE, ST_T0, ST_T1, ST_T2, ST_EXEC, ST_HALT} seq_state_t;

  typedef enum logic [2:0] {CLS_R3, CLS_IMM, CLS_R2, CLS_MD, CLS_NOP, CLS_HALT, CLS_ILL} instr_cls_t;

  typedef struct packed {
    logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read;
    logic MDRin, MDRout, IRin, Yin, Cout, HIin, LOin;
  } strobe_t;

  function automatic instr_cls_t decode_cls(logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return CLS_R3;
      OP_ADDI, OP_ANDI, OP_ORI:                      return CLS_IMM;
      OP_NEG, OP_NOT:                                return CLS_R2;
      OP_MUL, OP_DIV:                                return CLS_MD;
      OP_NOP:                                        return CLS_NOP;
      OP_HALT:                                       return CLS_HALT;
      default:                                       return CLS_ILL;
    endcase
  endfunction

  // Index of the final T-step for each class; classes without execute steps end at T2.
  function automatic int last_step(instr_cls_t c);
    case (c)
      CLS_R3, CLS_IMM: return 5;
      CLS_R2:          return 4;
      CLS_MD:          return 6;
      default:         return 2;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath (slave).
interface ctrl_sequencer_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5,
  parameter int NUM_REGS     = 16,
  parameter int MAX_STEPS    = 8
);
  logic                    run, stop, mem_ready;
  logic [DATA_WIDTH-1:0]   IR;
  logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read;
  logic MDRin, MDRout, IRin, Yin, Cout, HIin, LOin;
  logic [NUM_REGS-1:0]     reg_in, reg_out;
  logic [OPCODE_WIDTH-1:0] alu_op;
  logic [MAX_STEPS-1:0]    step;
  logic                    illegal, halted;

  modport master (
    input  run, stop, mem_ready, IR,
    output PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read,
    output MDRin, MDRout, IRin, Yin, Cout, HIin, LOin,
    output reg_in, reg_out, alu_op, step, illegal, halted
  );

  modport slave (
    output run, stop, mem_ready, IR,
    input  PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read,
    input  MDRin, MDRout, IRin, Yin, Cout, HIin, LOin,
    input  reg_in, reg_out, alu_op, step, illegal, halted
  );
endinterface

// File: rtl/reg_select_decoder.sv
// Register-field to one-hot enable decoder, fully gated by en.
module reg_select_decoder #(
  parameter int NUM_REGS = 16,
  parameter int RW       = $clog2(NUM_REGS)
) (
  input  logic                en,
  input  logic [RW-1:0]       sel,
  output logic [NUM_REGS-1:0] onehot
);
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    assign onehot[i] = en && (sel == RW'(i));
  end
endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the bus datapath. Outputs are
// decoded from registered state; IR fields are captured as T2 closes.
module ctrl_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5,
  parameter int NUM_REGS     = 16,
  parameter int MAX_STEPS    = 8
) (
  input logic            Clock,
  input logic            clear,
  ctrl_sequencer_if.master bus
);
  localparam int RW    = $clog2(NUM_REGS);
  localparam int SW    = $clog2(MAX_STEPS);
  localparam int RA_HI = field_hi(DATA_WIDTH, OPCODE_WIDTH, RW, FLD_RA);
  localparam int RB_HI = field_hi(DATA_WIDTH, OPCODE_WIDTH, RW, FLD_RB);
  localparam int RC_HI = field_hi(DATA_WIDTH, OPCODE_WIDTH, RW, FLD_RC);

  seq_state_t              state, state_nx, done_st;
  logic [SW-1:0]           stp, stp_nx;
  logic                    t1_wait, stop_pending, illegal_q;
  instr_cls_t              cls_q, ir_cls;
  logic [OPCODE_WIDTH-1:0] op_q, ir_op;
  logic [RW-1:0]           ra_q, rb_q, rc_q, rout_sel;
  logic                    rin_en, rout_en;
  logic [OPCODE_WIDTH-1:0] alu_op_c;
  strobe_t                 s;

  assign ir_op  = bus.IR[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign ir_cls = decode_cls(5'(ir_op));
  // A stop arriving in the final step still ends the run after this instruction.
  assign done_st = (bus.run && !(stop_pending || bus.stop)) ? ST_T0 : ST_IDLE;

  always_comb begin
    state_nx = state;
    stp_nx   = stp;
    case (state)
      ST_IDLE: if (bus.run) begin state_nx = ST_T0; stp_nx = '0; end
      ST_T0:   begin state_nx = ST_T1; stp_nx = SW'(1); end
      ST_T1:   if (bus.mem_ready) begin state_nx = ST_T2; stp_nx = SW'(2); end
      ST_T2: begin
        stp_nx = '0;
        case (ir_cls)
          CLS_HALT:         state_nx = ST_HALT;
          CLS_NOP, CLS_ILL: state_nx = done_st;
          default: begin state_nx = ST_EXEC; stp_nx = SW'(3); end
        endcase
      end
      ST_EXEC: begin
        if (stp == SW'(last_step(cls_q))) begin
          state_nx = done_st;
          stp_nx   = '0;
        end else begin
          stp_nx = stp + SW'(1);
        end
      end
      default: begin state_nx = state; stp_nx = '0; end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state        <= ST_IDLE;
      stp          <= '0;
      t1_wait      <= 1'b0;
      stop_pending <= 1'b0;
      illegal_q    <= 1'b0;
      cls_q        <= CLS_NOP;
      op_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      rc_q         <= '0;
    end else begin
      state        <= state_nx;
      stp          <= stp_nx;
      t1_wait      <= (state == ST_T1) && (state_nx == ST_T1);
      stop_pending <= (state_nx == ST_IDLE && state != ST_IDLE) ? 1'b0 : (stop_pending || bus.stop);
      illegal_q    <= (state == ST_T2) && (ir_cls == CLS_ILL);
      if (state == ST_T2) begin
        cls_q <= ir_cls;
        op_q  <= ir_op;
        ra_q  <= bus.IR[RA_HI -: RW];
        rb_q  <= bus.IR[RB_HI -: RW];
        rc_q  <= bus.IR[RC_HI -: RW];
      end
    end
  end

  always_comb begin
    s        = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rb_q;
    alu_op_c = '0;
    case (state)
      ST_T0: begin s.PCout = 1'b1; s.MARin = 1'b1; s.IncPC = 1'b1; s.Zin = 1'b1; end
      ST_T1: begin s.ZLOout = 1'b1; s.Read = 1'b1; s.MDRin = 1'b1; s.PCin = !t1_wait; end
      ST_T2: begin s.MDRout = 1'b1; s.IRin = 1'b1; end
      ST_EXEC: begin
        case (cls_q)
          CLS_R3, CLS_IMM: begin
            if (stp == SW'(3)) begin rout_en = 1'b1; s.Yin = 1'b1; end
            if (stp == SW'(4)) begin
              if (cls_q == CLS_IMM) s.Cout = 1'b1;
              else begin rout_en = 1'b1; rout_sel = rc_q; end
              alu_op_c = op_q;
              s.Zin    = 1'b1;
            end
            if (stp == SW'(5)) begin s.ZLOout = 1'b1; rin_en = 1'b1; end
          end
          CLS_R2: begin
            if (stp == SW'(3)) begin rout_en = 1'b1; alu_op_c = op_q; s.Zin = 1'b1; end
            if (stp == SW'(4)) begin s.ZLOout = 1'b1; rin_en = 1'b1; end
          end
          CLS_MD: begin
            if (stp == SW'(3)) begin rout_en = 1'b1; rout_sel = ra_q; s.Yin = 1'b1; end
            if (stp == SW'(4)) begin rout_en = 1'b1; alu_op_c = op_q; s.Zin = 1'b1; end
            if (stp == SW'(5)) begin s.ZLOout = 1'b1; s.LOin = 1'b1; end
            if (stp == SW'(6)) begin s.ZHIout = 1'b1; s.HIin = 1'b1; end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS), .RW(RW)) u_rin_dec (
    .en(rin_en), .sel(ra_q), .onehot(bus.reg_in));
  reg_select_decoder #(.NUM_REGS(NUM_REGS), .RW(RW)) u_rout_dec (
    .en(rout_en), .sel(rout_sel), .onehot(bus.reg_out));

  assign bus.PCout   = s.PCout;
  assign bus.MARin   = s.MARin;
  assign bus.IncPC   = s.IncPC;
  assign bus.Zin     = s.Zin;
  assign bus.ZLOout  = s.ZLOout;
  assign bus.ZHIout  = s.ZHIout;
  assign bus.PCin    = s.PCin;
  assign bus.Read    = s.Read;
  assign bus.MDRin   = s.MDRin;
  assign bus.MDRout  = s.MDRout;
  assign bus.IRin    = s.IRin;
  assign bus.Yin     = s.Yin;
  assign bus.Cout    = s.Cout;
  assign bus.HIin    = s.HIin;
  assign bus.LOin    = s.LOin;
  assign bus.alu_op  = alu_op_c;
  assign bus.step    = (state == ST_IDLE || state == ST_HALT) ? '0 : (MAX_STEPS'(1) << stp);
  assign bus.illegal = illegal_q;
  assign bus.halted  = (state == ST_HALT);

  a_step_limit: assert property (@(posedge Clock) disable iff (clear)
    (state == ST_T2) |-> (last_step(ir_cls) < MAX_STEPS));

  a_one_driver: assert property (@(posedge Clock) disable iff (clear)
    (state != ST_IDLE && state != ST_HALT) |->
      $onehot({bus.reg_out, s.PCout, s.ZLOout, s.ZHIout, s.MDRout, s.Cout}));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed-vector bench for ctrl_sequencer; expected strobes are hand-derived per T-step.
module tb_ctrl_sequencer;
  logic Clock = 1'b0;
  logic clear;
  always #5 Clock = ~Clock;

  ctrl_sequencer_if #(.DATA_WIDTH(32), .OPCODE_WIDTH(5), .NUM_REGS(16), .MAX_STEPS(8)) bus ();
  ctrl_sequencer #(.DATA_WIDTH(32), .OPCODE_WIDTH(5), .NUM_REGS(16), .MAX_STEPS(8)) dut (
    .Clock(Clock), .clear(clear), .bus(bus));

  localparam logic [14:0] PCOUT = 15'h4000, MARIN = 15'h2000, INCPC = 15'h1000, ZIN = 15'h0800;
  localparam logic [14:0] ZLO = 15'h0400, ZHI = 15'h0200, PCIN = 15'h0100, READ = 15'h0080;
  localparam logic [14:0] MDRIN = 15'h0040, MDROUT = 15'h0020, IRIN = 15'h0010, YIN = 15'h0008;
  localparam logic [14:0] COUT = 15'h0004, HIIN = 15'h0002, LOIN = 15'h0001;
  localparam logic [14:0] T0_S = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [14:0] T1_S = ZLO | READ | MDRIN;
  localparam logic [14:0] T2_S = MDROUT | IRIN;

  localparam logic [31:0] IR_NEG  = 32'h88918000;  // NEG R1,R2
  localparam logic [31:0] IR_ADD  = 32'h19A28000;  // ADD R3,R4,R5
  localparam logic [31:0] IR_MUL  = 32'h7B380000;  // MUL R6,R7
  localparam logic [31:0] IR_ADDI = 32'h60900005;  // ADDI R1,R2,5
  localparam logic [31:0] IR_ILL  = 32'hF8000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  logic [14:0] stb;
  logic [63:0] all_outs;
  assign stb = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.ZLOout, bus.ZHIout, bus.PCin,
                bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Cout, bus.HIin, bus.LOin};
  assign all_outs = {2'b00, stb, bus.reg_in, bus.reg_out, bus.alu_op, bus.step, bus.illegal, bus.halted};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_t(input string tag, input int idx, input logic [14:0] s,
                          input logic [15:0] rin, input logic [15:0] rout, input logic [4:0] alu);
    chk({tag, "_step"}, bus.step, 64'(1) << idx);
    chk({tag, "_stb"}, stb, s);
    chk({tag, "_rin"}, bus.reg_in, rin);
    chk({tag, "_rout"}, bus.reg_out, rout);
    chk({tag, "_alu"}, bus.alu_op, alu);
  endtask

  task automatic wait_step(input int idx, input string tag);
    int n = 0;
    while (bus.step !== (8'(1) << idx) && n < 20) begin
      @(negedge Clock);
      n++;
    end
    chk(tag, bus.step, 64'(1) << idx);
  endtask

  initial begin
    clear = 1'b1; bus.run = 1'b0; bus.stop = 1'b0; bus.mem_ready = 1'b1; bus.IR = IR_NEG;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("reset", all_outs, 64'h0);
    clear = 1'b0; bus.run = 1'b1;

    // NEG R1,R2 with zero-wait memory
    wait_step(0, "neg_start");
    expect_t("neg_t0", 0, T0_S, 16'h0, 16'h0, 5'b0);              @(negedge Clock);
    expect_t("neg_t1", 1, T1_S | PCIN, 16'h0, 16'h0, 5'b0);       @(negedge Clock);
    expect_t("neg_t2", 2, T2_S, 16'h0, 16'h0, 5'b0);              @(negedge Clock);
    expect_t("neg_t3", 3, ZIN, 16'h0, 16'h0004, 5'b10001);        @(negedge Clock);
    expect_t("neg_t4", 4, ZLO, 16'h0002, 16'h0, 5'b0);            @(negedge Clock);
    chk("neg_next_t0", bus.step, 64'h1);

    // ADD R3,R4,R5 with three wait cycles in T1
    bus.IR = IR_ADD; bus.mem_ready = 1'b0;
    @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      expect_t($sformatf("add_t1_%0d", i), 1, (i == 0) ? (T1_S | PCIN) : T1_S, 16'h0, 16'h0, 5'b0);
      if (i == 3) bus.mem_ready = 1'b1;
      @(negedge Clock);
    end
    expect_t("add_t2", 2, T2_S, 16'h0, 16'h0, 5'b0);              @(negedge Clock);
    expect_t("add_t3", 3, YIN, 16'h0, 16'h0010, 5'b0);            @(negedge Clock);
    expect_t("add_t4", 4, ZIN, 16'h0, 16'h0020, 5'b00011);        @(negedge Clock);
    expect_t("add_t5", 5, ZLO, 16'h0008, 16'h0, 5'b0);            @(negedge Clock);
    chk("add_next_t0", bus.step, 64'h1);

    // MUL R6,R7
    bus.IR = IR_MUL;
    wait_step(3, "mul_reach_t3");
    expect_t("mul_t3", 3, YIN, 16'h0, 16'h0040, 5'b0);            @(negedge Clock);
    expect_t("mul_t4", 4, ZIN, 16'h0, 16'h0080, 5'b01111);        @(negedge Clock);
    expect_t("mul_t5", 5, ZLO | LOIN, 16'h0, 16'h0, 5'b0);        @(negedge Clock);
    expect_t("mul_t6", 6, ZHI | HIIN, 16'h0, 16'h0, 5'b0);        @(negedge Clock);
    chk("mul_next_t0", bus.step, 64'h1);

    // ADDI with a stop pulse during T1
    bus.IR = IR_ADDI;
    @(negedge Clock);
    chk("addi_in_t1", bus.step, 64'h2);
    bus.stop = 1'b1;
    @(negedge Clock);
    bus.stop = 1'b0;
    wait_step(3, "addi_reach_t3");
    expect_t("addi_t3", 3, YIN, 16'h0, 16'h0004, 5'b0);           @(negedge Clock);
    expect_t("addi_t4", 4, ZIN | COUT, 16'h0, 16'h0, 5'b01100);   @(negedge Clock);
    expect_t("addi_t5", 5, ZLO, 16'h0002, 16'h0, 5'b0);           @(negedge Clock);
    chk("addi_idle", all_outs, 64'h0);

    // Undefined opcode, then HALT
    bus.IR = IR_ILL;
    wait_step(2, "ill_reach_t2");
    @(negedge Clock);
    chk("ill_pulse", bus.illegal, 64'h1);
    chk("ill_no_rin", bus.reg_in, 64'h0);
    chk("ill_next_t0", bus.step, 64'h1);
    bus.IR = IR_HALT;
    @(negedge Clock);
    chk("ill_one_cycle", bus.illegal, 64'h0);
    @(negedge Clock);
    @(negedge Clock);
    chk("halt_enter", all_outs, 64'h1);
    repeat (3) @(negedge Clock);
    chk("halt_hold", all_outs, 64'h1);
    clear = 1'b1;
    @(negedge Clock);
    chk("halt_clear", all_outs, 64'h0);

    // clear during T4 of ADD aborts before the T5 register write
    clear = 1'b0; bus.IR = IR_ADD;
    wait_step(4, "abort_reach_t4");
    chk("abort_t4_rout", bus.reg_out, 64'h0020);
    clear = 1'b1;
    @(negedge Clock);
    chk("abort_outs", all_outs, 64'h0);
    clear = 1'b0; bus.run = 1'b0;
    @(negedge Clock);
    chk("abort_idle", all_outs, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
